// File: rtl/umi_host_arbiter_pkg.sv
// UMI opcode constants, command field positions and arbiter state type
// shared by the two-requester UMI host arbiter.
package umi_arb_pkg;

    localparam logic [4:0] REQ_RD       = 5'h01;
    localparam logic [4:0] REQ_WR       = 5'h03;
    localparam logic [4:0] REQ_WRPOSTED = 5'h05;
    localparam logic [4:0] REQ_RDMA     = 5'h07;
    localparam logic [4:0] REQ_ATOMIC   = 5'h09;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 4;
    localparam int unsigned EOM_BIT    = 22;

    typedef enum logic [1:0] {
        ARB_OPEN  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

    // Requests that expect a response and therefore need a return tag.
    function automatic logic is_nonposted(input logic [4:0] opcode);
        case (opcode)
            REQ_RD, REQ_WR, REQ_RDMA, REQ_ATOMIC: return 1'b1;
            REQ_WRPOSTED:                         return 1'b0;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/umi_host_arbiter_if.sv
// One UMI channel: valid/ready handshake plus command, addresses and data.
interface umi_host_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 32,
    parameter int unsigned AW = 64
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;

    modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
    modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);
endinterface

// File: rtl/umi_host_arbiter_tag_fifo.sv
// In-order return-tag FIFO: one bit per outstanding non-posted request,
// recording which requester issued it.
module umi_arb_tag_fifo #(
    parameter int unsigned TDEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic                     push_tag,
    input  logic                     pop,
    output logic                     head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(TDEPTH):0] count
);
    localparam int unsigned PW   = $clog2(TDEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [TDEPTH-1:0] mem;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_en;
    logic              pop_en;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(TDEPTH));
    assign head    = mem[rd_ptr];
    // A push into a full FIFO is legal only alongside a pop of the old head.
    assign push_en = push && (!full || pop);
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/umi_host_arbiter.sv
// Two-requester UMI host arbiter: round-robin grant locked per packet, responses
// returned to the issuing requester through an in-order tag FIFO.
module umi_host_arbiter
    import umi_arb_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned CW     = 32,
    parameter int unsigned AW     = 64,
    parameter int unsigned TDEPTH = 8
) (
    input  logic                     clk,
    input  logic                     nreset,
    umi_host_arbiter_if.slave        req0,
    umi_host_arbiter_if.slave        req1,
    umi_host_arbiter_if.master       uhost_req,
    umi_host_arbiter_if.slave        uhost_resp,
    umi_host_arbiter_if.master       resp0,
    umi_host_arbiter_if.master       resp1,
    output logic [$clog2(TDEPTH):0] outstanding,
    output logic                     err_orphan
);
    arb_state_e    state_q, state_d;
    logic          rr_q, rr_d;
    logic          gnt_valid, gnt_idx, gnt_beat_valid;
    logic          accept, tag_push, tag_pop;
    logic [CW-1:0] gnt_cmd;
    logic [AW-1:0] gnt_dstaddr, gnt_srcaddr;
    logic [DW-1:0] gnt_data;
    logic          fifo_head, fifo_empty, fifo_full;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        state_d   = state_q;
        rr_d      = rr_q;
        case (state_q)
            ARB_LOCK0: begin gnt_valid = 1'b1; gnt_idx = 1'b0; end
            ARB_LOCK1: begin gnt_valid = 1'b1; gnt_idx = 1'b1; end
            default: begin
                // New packets only start while a return tag is still available.
                if (!fifo_full) begin
                    if (req0.valid && req1.valid) begin gnt_valid = 1'b1; gnt_idx = rr_q; end
                    else if (req0.valid)          begin gnt_valid = 1'b1; gnt_idx = 1'b0; end
                    else if (req1.valid)          begin gnt_valid = 1'b1; gnt_idx = 1'b1; end
                end
            end
        endcase
        gnt_cmd        = gnt_idx ? req1.cmd     : req0.cmd;
        gnt_dstaddr    = gnt_idx ? req1.dstaddr : req0.dstaddr;
        gnt_srcaddr    = gnt_idx ? req1.srcaddr : req0.srcaddr;
        gnt_data       = gnt_idx ? req1.data    : req0.data;
        gnt_beat_valid = nreset && gnt_valid && (gnt_idx ? req1.valid : req0.valid);
        accept         = gnt_beat_valid && uhost_req.ready;
        tag_push       = accept && gnt_cmd[EOM_BIT] && is_nonposted(gnt_cmd[OPCODE_MSB:OPCODE_LSB]);
        if (accept) begin
            if (gnt_cmd[EOM_BIT]) begin
                state_d = ARB_OPEN;
                rr_d    = ~gnt_idx;
            end else begin
                state_d = gnt_idx ? ARB_LOCK1 : ARB_LOCK0;
            end
        end
    end

    assign uhost_req.valid   = gnt_beat_valid;
    assign uhost_req.cmd     = gnt_cmd;
    assign uhost_req.dstaddr = gnt_dstaddr;
    assign uhost_req.srcaddr = gnt_srcaddr;
    assign uhost_req.data    = gnt_data;
    assign req0.ready        = nreset && gnt_valid && !gnt_idx && uhost_req.ready;
    assign req1.ready        = nreset && gnt_valid &&  gnt_idx && uhost_req.ready;

    // With no tag outstanding the response is swallowed and flagged as orphan.
    assign resp0.valid      = nreset && !fifo_empty && !fifo_head && uhost_resp.valid;
    assign resp1.valid      = nreset && !fifo_empty &&  fifo_head && uhost_resp.valid;
    assign uhost_resp.ready = nreset && (fifo_empty ? 1'b1 : (fifo_head ? resp1.ready : resp0.ready));
    assign tag_pop          = !fifo_empty && uhost_resp.valid && uhost_resp.ready && uhost_resp.cmd[EOM_BIT];

    assign resp0.cmd     = uhost_resp.cmd;
    assign resp0.dstaddr = uhost_resp.dstaddr;
    assign resp0.srcaddr = uhost_resp.srcaddr;
    assign resp0.data    = uhost_resp.data;
    assign resp1.cmd     = uhost_resp.cmd;
    assign resp1.dstaddr = uhost_resp.dstaddr;
    assign resp1.srcaddr = uhost_resp.srcaddr;
    assign resp1.data    = uhost_resp.data;

    umi_arb_tag_fifo #(.TDEPTH(TDEPTH)) u_tag_fifo (
        .clk      (clk),
        .nreset   (nreset),
        .push     (tag_push),
        .push_tag (gnt_idx),
        .pop      (tag_pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (outstanding)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= ARB_OPEN;
            rr_q       <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (uhost_resp.valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule
